reg_wb_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback and the long-latency unit (mul/div, and later the load miss path). It keeps a one-entry holding buffer for long-latency results displaced by pipeline writebacks. A busy scoreboard of outstanding long-latency destinations drives the decode-stage stall, so operands are never read while stale. It sits between the writeback stage and the register file's rd write port, next to decode.

---
 rtl/reg_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_reg_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and long-latency
// results are parked in a one-entry holding buffer. A busy scoreboard drives the decode stall.
module reg_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            lu_issue,
    input  logic [4:0]      lu_issue_addr,
    input  logic            lu_valid,
    input  logic [4:0]      lu_addr,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_rden,
    input  logic            rs2_rden,
    input  logic [4:0]      dec_rd_addr,
    input  logic            dec_rd_wren,
    output logic            stall,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [31:0]     busy_q, busy_d;
    logic            hold_valid_q, hold_valid_d;
    logic [4:0]      hold_addr_q, hold_addr_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic [3:0]      starve_q, starve_d;

    logic            lu_acc;
    logic            lu_wr;
    logic [4:0]      lu_wr_addr;
    logic [31:0]     busy_eff;

    // Write-port mux: wb first, then the held result, then a direct lu result.
    always_comb begin
        lu_ready   = ~hold_valid_q & ~rst;
        lu_acc     = lu_valid & lu_ready;
        rd_wren    = 1'b0;
        rd_addr    = '0;
        rd_data    = '0;
        lu_wr      = 1'b0;
        lu_wr_addr = '0;
        if (!rst) begin
            if (wb_valid) begin
                rd_wren = 1'b1;
                rd_addr = wb_addr;
                rd_data = wb_data;
            end else if (hold_valid_q) begin
                rd_wren    = 1'b1;
                rd_addr    = hold_addr_q;
                rd_data    = hold_data_q;
                lu_wr      = 1'b1;
                lu_wr_addr = hold_addr_q;
            end else if (lu_acc) begin
                rd_wren    = 1'b1;
                rd_addr    = lu_addr;
                rd_data    = lu_data;
                lu_wr      = 1'b1;
                lu_wr_addr = lu_addr;
            end
        end
    end

    // The register file bypasses an lu write, so that address is already safe to read.
    always_comb begin
        busy_eff = busy_q;
        if (lu_wr) begin
            busy_eff[lu_wr_addr] = 1'b0;
        end
        stall = ~rst & ((rs1_rden    & busy_eff[rs1_addr])    |
                        (rs2_rden    & busy_eff[rs2_addr])    |
                        (dec_rd_wren & busy_eff[dec_rd_addr]) |
                        (starve_q == STARVE_LIM));
    end

    always_comb begin
        busy_d = busy_q;
        if (lu_wr) begin
            busy_d[lu_wr_addr] = 1'b0;
        end
        if (lu_issue && lu_issue_addr != 5'd0) begin
            busy_d[lu_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        if (lu_acc && wb_valid) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = lu_addr;
            hold_data_d  = lu_data;
        end else if (hold_valid_q && !wb_valid) begin
            hold_valid_d = 1'b0;
        end

        starve_d = '0;
        if (hold_valid_q && wb_valid) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            starve_q     <= '0;
        end else begin
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            starve_q     <= starve_d;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and randomized checks of reg_wb_arbiter against a behavioural model
// of the write-port arbitration, holding buffer, scoreboard and starvation stall.
module tb_reg_wb_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            lu_issue;
    logic [4:0]      lu_issue_addr;
    logic            lu_valid;
    logic [4:0]      lu_addr;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready;
    logic [4:0]      rs1_addr, rs2_addr;
    logic            rs1_rden, rs2_rden;
    logic [4:0]      dec_rd_addr;
    logic            dec_rd_wren;
    logic            stall;
    logic            rd_wren;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    reg_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rden(rs1_rden), .rs2_rden(rs2_rden),
        .dec_rd_addr(dec_rd_addr), .dec_rd_wren(dec_rd_wren), .stall(stall),
        .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference state: set of outstanding destinations, parked result, starvation age.
    bit          mbusy [32];
    bit          m_hold_v;
    logic [4:0]  m_hold_a;
    logic [31:0] m_hold_d;
    int unsigned m_starve;

    logic        e_wren, e_ready, e_stall, e_accept, e_lu_write;
    logic [4:0]  e_addr, e_lu_waddr;
    logic [31:0] e_data;

    function automatic bit eff_busy(logic [4:0] a);
        return mbusy[a] && !(e_lu_write && e_lu_waddr == a);
    endfunction

    task automatic model_comb();
        e_wren     = 1'b0;
        e_addr     = '0;
        e_data     = '0;
        e_lu_write = 1'b0;
        e_lu_waddr = '0;
        e_ready    = !rst && !m_hold_v;
        e_accept   = lu_valid && e_ready;
        if (!rst) begin
            if (wb_valid) begin
                e_wren = 1'b1; e_addr = wb_addr; e_data = wb_data;
            end else if (m_hold_v) begin
                e_wren = 1'b1; e_addr = m_hold_a; e_data = m_hold_d;
                e_lu_write = 1'b1; e_lu_waddr = m_hold_a;
            end else if (e_accept) begin
                e_wren = 1'b1; e_addr = lu_addr; e_data = lu_data;
                e_lu_write = 1'b1; e_lu_waddr = lu_addr;
            end
        end
        e_stall = !rst && ((rs1_rden && eff_busy(rs1_addr)) ||
                           (rs2_rden && eff_busy(rs2_addr)) ||
                           (dec_rd_wren && eff_busy(dec_rd_addr)) ||
                           (m_starve == STARVE_MAX));
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, vectors);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled at the falling edge.
    task automatic settle();
        model_comb();
        if (!rst) begin
            if (wb_valid)
                assert (!mbusy[wb_addr]) else $fatal(1, "FAIL precond_wb: x%0d busy", wb_addr);
            if (lu_issue)
                assert (!e_stall) else $fatal(1, "FAIL precond_issue: issued under stall");
            if (lu_valid)
                assert (lu_addr == 5'd0 || mbusy[lu_addr]) else $fatal(1, "FAIL precond_lu: x%0d not busy", lu_addr);
        end
        #4;
        vectors++;
        check("rd_wren",  32'(rd_wren),  32'(e_wren));
        check("lu_ready", 32'(lu_ready), 32'(e_ready));
        check("stall",    32'(stall),    32'(e_stall));
        if (e_wren) begin
            check("rd_addr", 32'(rd_addr), 32'(e_addr));
            check("rd_data", rd_data, e_data);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            foreach (mbusy[k]) mbusy[k] = 1'b0;
            m_hold_v = 1'b0;
            m_starve = 0;
        end else begin
            if (e_lu_write) mbusy[e_lu_waddr] = 1'b0;
            if (lu_issue && lu_issue_addr != 5'd0) mbusy[lu_issue_addr] = 1'b1;
            if (wb_valid && m_hold_v)
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else
                m_starve = 0;
            if (wb_valid && e_accept) begin
                m_hold_v = 1'b1; m_hold_a = lu_addr; m_hold_d = lu_data;
            end else if (!wb_valid) begin
                m_hold_v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle();
        rst = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        lu_issue = 1'b0; lu_issue_addr = '0; lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_rden = 1'b0; rs2_rden = 1'b0;
        dec_rd_addr = '0; dec_rd_wren = 1'b0;
    endtask

    initial begin
        bit          found;
        logic [4:0]  a;
        int unsigned start;

        foreach (mbusy[k]) mbusy[k] = 1'b0;
        m_hold_v = 1'b0; m_hold_a = '0; m_hold_d = '0; m_starve = 0;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        tick();
        idle();
        tick();

        // Plain writeback, zero latency
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        settle();
        check("tp_wb_data", rd_data, 32'hDEADBEEF);
        check("tp_wb_ready", 32'(lu_ready), 32'd1);
        advance();

        // RAW stall until the lu result is written, bypassed in the write cycle
        idle(); lu_issue = 1'b1; lu_issue_addr = 5'd7; tick();
        idle(); rs1_rden = 1'b1; rs1_addr = 5'd7;
        settle(); check("tp_raw_stall", 32'(stall), 32'd1); advance();
        tick(); tick();
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h1234;
        settle();
        check("tp_raw_bypass", 32'(stall), 32'd0);
        check("tp_raw_data", rd_data, 32'h1234);
        advance();
        idle(); tick();

        // Collision: lu result parked, drained on the first idle writeback cycle
        lu_issue = 1'b1; lu_issue_addr = 5'd9; tick();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h55;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h66;
        settle(); check("tp_col_wb", 32'(rd_addr), 32'd3); advance();
        idle();
        settle();
        check("tp_drain_addr", 32'(rd_addr), 32'd9);
        check("tp_drain_data", rd_data, 32'h55);
        check("tp_drain_ready", 32'(lu_ready), 32'd0);
        advance();
        settle(); check("tp_ready_back", 32'(lu_ready), 32'd1); advance();

        // Starvation: hold stays full under continuous writeback
        lu_issue = 1'b1; lu_issue_addr = 5'd9; tick();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'hA5A5;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1;
        tick();
        lu_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wb_data = 32'(i + 2);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();

        // WAW stall, then simultaneous issue and write of the same register
        lu_issue = 1'b1; lu_issue_addr = 5'd12; tick();
        idle(); dec_rd_wren = 1'b1; dec_rd_addr = 5'd12;
        settle(); check("tp_waw", 32'(stall), 32'd1); advance();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h12;
        lu_issue = 1'b1; lu_issue_addr = 5'd12;
        tick();
        idle(); rs1_rden = 1'b1; rs1_addr = 5'd12;
        settle(); check("tp_set_wins", 32'(stall), 32'd1); advance();
        idle(); lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h13; tick();
        idle(); tick();

        // Reset with hold full and x4 outstanding
        lu_issue = 1'b1; lu_issue_addr = 5'd9; tick();
        lu_issue_addr = 5'd4; tick();
        idle();
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        tick();
        idle(); rst = 1'b1;
        settle();
        check("tp_rst_wren", 32'(rd_wren), 32'd0);
        check("tp_rst_ready", 32'(lu_ready), 32'd0);
        check("tp_rst_stall", 32'(stall), 32'd0);
        advance();
        idle(); rs1_rden = 1'b1; rs1_addr = 5'd4;
        settle();
        check("tp_post_rst_stall", 32'(stall), 32'd0);
        check("tp_post_rst_wren", 32'(rd_wren), 32'd0);
        advance();

        // Randomized traffic with alternating dense and sparse writeback phases
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst      = ($urandom_range(0, 199) == 0);
            wb_valid = ($urandom_range(0, 99) < ((((i / 250) % 2) != 0) ? 92 : 40));
            wb_addr  = 5'($urandom_range(0, 31));
            if (mbusy[wb_addr]) wb_addr = 5'd0;
            wb_data  = $urandom;
            found = 1'b0;
            a     = '0;
            start = $urandom_range(0, 31);
            for (int k = 0; k < 32; k++) begin
                if (!found && mbusy[(start + k) % 32]) begin
                    found = 1'b1;
                    a     = 5'((start + k) % 32);
                end
            end
            if (found && $urandom_range(0, 1) == 0) begin
                lu_valid = 1'b1; lu_addr = a; lu_data = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                lu_valid = 1'b1; lu_addr = 5'd0; lu_data = $urandom;
            end
            rs1_rden    = 1'($urandom_range(0, 1));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_rden    = 1'($urandom_range(0, 1));
            rs2_addr    = 5'($urandom_range(0, 31));
            dec_rd_wren = 1'($urandom_range(0, 1));
            dec_rd_addr = 5'($urandom_range(0, 31));
            model_comb();
            if (!rst && !e_stall && $urandom_range(0, 2) == 0) begin
                lu_issue      = 1'b1;
                lu_issue_addr = dec_rd_wren ? dec_rd_addr : 5'($urandom_range(0, 31));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
